uart_rx_cfg: RTL and testbench

Parametrised UART receiver: the next-generation receive path of the UART. It synchronises and majority-filters the serial line, generates its own mid-bit sampling from a bit-period counter, and deframes configurable character formats (data bits, parity, stop bits). Each received character is presented with parity, framing and overrun status under a ready/acknowledge handshake. It sits between the RXD pin and the host/register interface.

---
 rtl/uart_rx_cfg.sv | 173 +++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// UART receive path: synchronised, majority-filtered RXD, mid-bit sampling from a
// bit-period counter, configurable deframing and a ready/ACK result register.
module uart_rx_cfg #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 RXD,
    input  logic                 ACK,
    output logic [DATA_BITS-1:0] DQ,
    output logic                 RX_READY,
    output logic                 PERR,
    output logic                 FERR,
    output logic                 OVR
);

    localparam int   H   = CLKS_PER_BIT / 2;
    localparam int   CW  = $clog2(CLKS_PER_BIT);
    localparam logic ODD = (PARITY_ODD != 0);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [1:0]           sync_q;
    logic [2:0]           taps_q;
    logic                 filt_q;
    logic [5:0]           fill_q;
    logic                 armed_q, armed_d;
    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic                 par_q, par_d;
    logic                 facc_q, facc_d;
    logic [DATA_BITS-1:0] dq_q, dq_d;
    logic                 rdy_q, rdy_d, perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;
    logic                 sample, done;

    // fill_q marks when FILT no longer carries reset-loaded ones.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q <= '1;
            taps_q <= '1;
            filt_q <= 1'b1;
            fill_q <= '0;
        end else begin
            sync_q <= {sync_q[0], RXD};
            taps_q <= {taps_q[1:0], sync_q[1]};
            filt_q <= (taps_q[0] & taps_q[1]) | (taps_q[0] & taps_q[2]) | (taps_q[1] & taps_q[2]);
            fill_q <= {fill_q[4:0], 1'b1};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            facc_q  <= 1'b0;
            armed_q <= 1'b0;
            dq_q    <= '0;
            rdy_q   <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            facc_q  <= facc_d;
            armed_q <= armed_d;
            dq_q    <= dq_d;
            rdy_q   <= rdy_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        par_d   = par_q;
        facc_d  = facc_q;
        armed_d = armed_q;
        dq_d    = dq_q;
        rdy_d   = rdy_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;
        done    = 1'b0;
        sample  = (cnt_q == CW'(CLKS_PER_BIT - 1));

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                // A start needs a genuine high level first, so a low line after reset is ignored.
                if (fill_q[5] && filt_q) armed_d = 1'b1;
                if (armed_q && !filt_q) begin
                    state_d = S_START;
                    armed_d = 1'b0;
                end
            end
            S_START: begin
                if (cnt_q == CW'(H - 1)) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    par_d   = 1'b0;
                    facc_d  = 1'b0;
                    state_d = filt_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                if (!sample) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = '0;
                    if (state_q == S_DATA) begin
                        sh_d  = {filt_q, sh_q[DATA_BITS-1:1]};
                        par_d = par_q ^ filt_q;
                        if (bit_q == 4'(DATA_BITS - 1)) begin
                            bit_d   = '0;
                            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end else if (state_q == S_PARITY) begin
                        par_d   = par_q ^ filt_q;
                        state_d = S_STOP;
                    end else begin
                        facc_d = facc_q | ~filt_q;
                        if (bit_q == 4'(STOP_BITS - 1)) begin
                            done    = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end
                end
            end
        endcase

        // A completion coinciding with ACK consumes the old character, so no overrun.
        if (done) begin
            dq_d   = sh_q;
            perr_d = (PARITY_EN != 0) && (par_q != ODD);
            ferr_d = facc_q | ~filt_q;
            ovr_d  = rdy_q & ~ACK;
            rdy_d  = 1'b1;
        end else if (ACK && rdy_q) begin
            rdy_d = 1'b0;
            ovr_d = 1'b0;
        end
    end

    assign DQ       = dq_q;
    assign RX_READY = rdy_q;
    assign PERR     = perr_q;
    assign FERR     = ferr_q;
    assign OVR      = ovr_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: three configurations (8N1, 7E1 at N=8, 8N2)
// driven with directed and random frames; expected results come from frame contents.
module tb_uart_rx_cfg;

    localparam int NI = 3;
    localparam int NB  [NI] = '{8, 7, 8};
    localparam int NN  [NI] = '{16, 8, 16};
    localparam int PE  [NI] = '{0, 1, 0};
    localparam int ODD [NI] = '{0, 0, 0};
    localparam int SB  [NI] = '{1, 1, 2};

    typedef struct {
        int         due;
        logic [8:0] dq;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd    [NI];
    logic       ack    [NI];
    logic       rdy    [NI];
    logic       perr_o [NI];
    logic       ferr_o [NI];
    logic       ovr_o  [NI];
    logic [7:0] dq0;
    logic [6:0] dq1;
    logic [7:0] dq2;
    logic [8:0] dq_all [NI];

    exp_t       sbq    [NI][$];
    logic       m_rdy  [NI];
    logic       m_ovr  [NI];
    logic       m_perr [NI];
    logic       m_ferr [NI];
    logic [8:0] m_dq   [NI];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    assign dq_all[0] = {1'b0, dq0};
    assign dq_all[1] = {2'b00, dq1};
    assign dq_all[2] = {1'b0, dq2};

    uart_rx_cfg #(.DATA_BITS(8), .CLKS_PER_BIT(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
        .CLK(clk), .RST(rst), .RXD(rxd[0]), .ACK(ack[0]), .DQ(dq0),
        .RX_READY(rdy[0]), .PERR(perr_o[0]), .FERR(ferr_o[0]), .OVR(ovr_o[0]));
    uart_rx_cfg #(.DATA_BITS(7), .CLKS_PER_BIT(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
        .CLK(clk), .RST(rst), .RXD(rxd[1]), .ACK(ack[1]), .DQ(dq1),
        .RX_READY(rdy[1]), .PERR(perr_o[1]), .FERR(ferr_o[1]), .OVR(ovr_o[1]));
    uart_rx_cfg #(.DATA_BITS(8), .CLKS_PER_BIT(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u2 (
        .CLK(clk), .RST(rst), .RXD(rxd[2]), .ACK(ack[2]), .DQ(dq2),
        .RX_READY(rdy[2]), .PERR(perr_o[2]), .FERR(ferr_o[2]), .OVR(ovr_o[2]));

    // Reference: expected output state after each rising edge (cyc = edge number).
    always @(posedge clk) begin
        exp_t e;
        cyc = cyc + 1;
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                m_rdy[i] = 0; m_ovr[i] = 0; m_perr[i] = 0; m_ferr[i] = 0; m_dq[i] = '0;
                sbq[i].delete();
            end else if (sbq[i].size() > 0 && sbq[i][0].due == cyc) begin
                e = sbq[i].pop_front();
                m_ovr[i]  = m_rdy[i] & ~ack[i];
                m_rdy[i]  = 1'b1;
                m_dq[i]   = e.dq;
                m_perr[i] = e.perr;
                m_ferr[i] = e.ferr;
            end else if (ack[i] && m_rdy[i]) begin
                m_rdy[i] = 1'b0;
                m_ovr[i] = 1'b0;
            end
        end
    end

    // Monitor: compare every DUT output against the reference mid-cycle.
    always @(negedge clk) begin
        if (cyc > 0) begin
            for (int i = 0; i < NI; i++) begin
                n_cmp++;
                if (rdy[i] !== m_rdy[i] || ovr_o[i] !== m_ovr[i] || dq_all[i] !== m_dq[i] ||
                    perr_o[i] !== m_perr[i] || ferr_o[i] !== m_ferr[i]) begin
                    n_bad++;
                    if (n_bad <= 20)
                        $display("FAIL outputs u%0d cyc %0d: got rdy=%b ovr=%b dq=%h perr=%b ferr=%b, want rdy=%b ovr=%b dq=%h perr=%b ferr=%b",
                                 i, cyc, rdy[i], ovr_o[i], dq_all[i], perr_o[i], ferr_o[i],
                                 m_rdy[i], m_ovr[i], m_dq[i], m_perr[i], m_ferr[i]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_ack(input int i);
        ack[i] = 1'b1;
        tick();
        ack[i] = 1'b0;
    endtask

    function automatic int frame_len(input int i);
        return 1 + NB[i] + PE[i] + SB[i];
    endfunction

    // RX_READY appears H + (F-1)*N + 6 cycles after the cycle the start bit is driven.
    function automatic int due_of(input int i, input int k);
        return k + NN[i] / 2 + (frame_len(i) - 1) * NN[i] + 6;
    endfunction

    task automatic send_frame(input int i, input logic [8:0] data, input bit pflip, input logic [1:0] stopv);
        logic bits[$];
        logic pbit;
        exp_t e;
        for (int b = 0; b < 9; b++) if (b >= NB[i]) data[b] = 1'b0;
        pbit = (^data) ^ ODD[i][0] ^ pflip;
        bits.push_back(1'b0);
        for (int b = 0; b < NB[i]; b++) bits.push_back(data[b]);
        if (PE[i] != 0) bits.push_back(pbit);
        e.ferr = 1'b0;
        for (int s = 0; s < SB[i]; s++) begin
            bits.push_back(stopv[s]);
            if (!stopv[s]) e.ferr = 1'b1;
        end
        e.due  = due_of(i, cyc);
        e.dq   = data;
        e.perr = (PE[i] != 0) && (((^data) ^ pbit) != ODD[i][0]);
        sbq[i].push_back(e);
        foreach (bits[b]) begin
            rxd[i] = bits[b];
            repeat (NN[i]) tick();
        end
        rxd[i] = 1'b1;
    endtask

    initial begin
        int         k1, target, guard, ri, gap;
        logic [8:0] rd;
        logic [1:0] sv;
        bit         pf;

        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            rxd[i] = 1'b1; ack[i] = 1'b0;
            m_rdy[i] = 0; m_ovr[i] = 0; m_perr[i] = 0; m_ferr[i] = 0; m_dq[i] = '0;
        end
        repeat (4) tick();
        rst = 1'b0;
        repeat (12) tick();

        send_frame(0, 9'h0A5, 1'b0, 2'b11);
        repeat (8) tick();
        pulse_ack(0);
        repeat (8) tick();

        rxd[0] = 1'b0; tick(); rxd[0] = 1'b1;
        repeat (20) tick();
        rxd[0] = 1'b0; repeat (6) tick(); rxd[0] = 1'b1;
        repeat (40) tick();

        send_frame(1, 9'h041, 1'b1, 2'b11);
        repeat (16) tick();
        pulse_ack(1);
        send_frame(1, 9'h041, 1'b0, 2'b11);
        repeat (16) tick();
        pulse_ack(1);

        send_frame(2, 9'h03C, 1'b0, 2'b01);
        repeat (32) tick();
        pulse_ack(2);
        repeat (8) tick();

        send_frame(0, 9'h011, 1'b0, 2'b11);
        send_frame(0, 9'h022, 1'b0, 2'b11);
        repeat (8) tick();
        pulse_ack(0);
        repeat (4) tick();

        k1 = cyc;
        target = due_of(0, k1 + frame_len(0) * NN[0]) - 1;
        fork
            begin
                send_frame(0, 9'h011, 1'b0, 2'b11);
                send_frame(0, 9'h022, 1'b0, 2'b11);
            end
            begin
                guard = 0;
                while (cyc < target && guard < 5000) begin
                    tick();
                    guard++;
                end
                pulse_ack(0);
            end
        join
        repeat (8) tick();
        pulse_ack(0);
        repeat (4) tick();

        fork
            send_frame(0, 9'h05A, 1'b0, 2'b11);
            begin
                repeat (8 * 16 + 8) tick();
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
        join
        repeat (48) tick();
        send_frame(0, 9'h05A, 1'b0, 2'b11);
        repeat (8) tick();
        pulse_ack(0);
        repeat (8) tick();

        for (int t = 0; t < 60; t++) begin
            ri = $urandom_range(0, NI - 1);
            rd = 9'($urandom);
            pf = (PE[ri] != 0) && ($urandom_range(0, 3) == 0);
            sv = 2'b11;
            for (int s = 0; s < 2; s++) if ($urandom_range(0, 7) == 0) sv[s] = 1'b0;
            send_frame(ri, rd, pf, sv);
            if ($urandom_range(0, 1) == 1) begin
                repeat (2 * NN[ri]) tick();
                pulse_ack(ri);
            end
            gap = $urandom_range(0, NN[ri]);
            if (!sv[SB[ri] - 1]) gap += NN[ri];
            repeat (gap) tick();
        end

        guard = 0;
        while ((sbq[0].size() + sbq[1].size() + sbq[2].size()) > 0 && guard < 3000) begin
            tick();
            guard++;
        end
        repeat (4) tick();
        n_cmp++;
        if ((sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0) begin
            n_bad++;
            $display("FAIL drain: %0d characters still expected, want 0",
                     sbq[0].size() + sbq[1].size() + sbq[2].size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
